jkff_bank: RTL and testbench

Parametrised bank of WIDTH JK flip-flops with a shared clock, asynchronous active-low reset, global enable and a 2-bit mode select. It is the multi-bit successor to the single JK flip-flop. The same bank serves as a raw JK register, a synchronous up counter, a down counter or a left shift register. Every mode is realised by deriving per-bit J/K drives into identical JK cells.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_cell.sv | 34 +++
 rtl/jkff_bank.sv | 105 ++++++++++
 tb/tb_jkff_bank.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK flip-flop bank.
//   mode_t     2-bit operating mode of jkff_bank
//   MODE_JK    raw per-bit JK register
//   MODE_UP    synchronous up counter
//   MODE_DOWN  synchronous down counter
//   MODE_SHIFT left shift register, serial-in on j[0]
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_t;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with asynchronous active-low reset.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; loads RST
//   j, k   JK drive: 00 hold, 10 set, 01 clear, 11 toggle
//   q      flip-flop output
//   qnot   always ~q, including while reset is asserted
module jk_cell #(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qnot
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST;
    end else begin
      unique case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qnot = ~q;

endmodule : jk_cell

// File: rtl/jkff_bank.sv
// jkff_bank: WIDTH JK flip-flops sharing clock, async active-low reset and
// a global enable. The mode select turns the bank into a raw JK register,
// an up counter, a down counter or a left shift register, purely by
// choosing the J/K drive of each identical cell.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; q <= RESET_VAL
//   en     global enable; 0 holds every bit
//   mode   MODE_JK / MODE_UP / MODE_DOWN / MODE_SHIFT
//   j, k   per-bit J/K in JK mode; j[0] is serial-in in SHIFT mode
//   q      register state
//   qnot   ~q
//   tc     terminal count: all ones in UP, all zeros in DOWN (when enabled)
module jkff_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc
);

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] jd;
  logic [WIDTH-1:0] kd;

  // Toggle enables for the counters: bit i toggles when all lower bits are
  // ones (up) or all lower bits are zeros (down). Built with scalar running
  // terms so no vector feeds back on itself.
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c = 1'b1;
    dn_c = 1'b1;
    up_t = '0;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_c;
      dn_t[i] = dn_c;
      up_c    = up_c & q[i];
      dn_c    = dn_c & ~q[i];
    end
  end

  assign shift_d = {q[WIDTH-2:0], j[0]};

  // J/K drive mux; J=K=0 holds, so a disabled bank simply drives zeros.
  always_comb begin
    jd = '0;
    kd = '0;
    if (en) begin
      unique case (mode)
        MODE_JK: begin
          jd = j;
          kd = k;
        end
        MODE_UP: begin
          jd = up_t;
          kd = up_t;
        end
        MODE_DOWN: begin
          jd = dn_t;
          kd = dn_t;
        end
        MODE_SHIFT: begin
          jd = shift_d;
          kd = ~shift_d;
        end
        default: begin
          jd = '0;
          kd = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (jd[i]),
      .k     (kd[i]),
      .q     (q[i]),
      .qnot  (qnot[i])
    );
  end

  // Gated with reset so tc reads 0 while reset is held, whatever RESET_VAL is.
  assign tc = reset & en &
              (((mode == MODE_UP)   &  (&q)) |
               ((mode == MODE_DOWN) & ~(|q)));

endmodule : jkff_bank

// File: tb/tb_jkff_bank.sv
// tb_jkff_bank: scenario-driven bench for jkff_bank (WIDTH=4). Expected
// results are pushed to a scoreboard queue as stimulus is applied and popped
// for comparison one time unit after the following rising edge.
module tb_jkff_bank;
  import jk_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  mode_t        mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qnot;
  logic         tc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
  } exp_t;

  typedef struct {
    logic         en;
    mode_t        mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    exp_t         e;
  } row_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jkff_bank #(
    .WIDTH     (W),
    .RESET_VAL (4'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .q     (q),
    .qnot  (qnot),
    .tc    (tc)
  );

  task automatic test_reset();
    row_t rows[$];
    exp_t got;
    reset = 1'b0;
    en    = 1'b1;
    mode  = MODE_DOWN;
    j     = '0;
    k     = '0;
    #2;
    n_cmp++;
    if (q !== 4'h0 || qnot !== 4'hF || tc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: q=%h qnot=%h tc=%b, want q=0 qnot=f tc=0", q, qnot, tc);
    end
    #7;
    reset = 1'b1;
    rows.push_back('{1'b0, MODE_JK, 4'hF, 4'hF, '{4'h0, 1'b0}});
    rows.push_back('{1'b0, MODE_JK, 4'hF, 4'hF, '{4'h0, 1'b0}});
    rows.push_back('{1'b0, MODE_JK, 4'hF, 4'hF, '{4'h0, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  task automatic test_jk();
    row_t rows[$];
    exp_t got;
    rows.push_back('{1'b1, MODE_JK, 4'b1010, 4'b0110, '{4'b1010, 1'b0}});
    rows.push_back('{1'b1, MODE_JK, 4'b1010, 4'b0110, '{4'b1000, 1'b0}});
    rows.push_back('{1'b1, MODE_JK, 4'b0000, 4'b0000, '{4'b1000, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL jk[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  task automatic test_up_wrap();
    row_t rows[$];
    exp_t got;
    rows.push_back('{1'b1, MODE_JK, 4'hE, 4'h1, '{4'hE, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'hF, 1'b1}});
    rows.push_back('{1'b1, MODE_UP, 4'h5, 4'hA, '{4'h0, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h1, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h2, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h3, 1'b0}});
    rows.push_back('{1'b0, MODE_UP, 4'hF, 4'hF, '{4'h3, 1'b0}});
    rows.push_back('{1'b0, MODE_UP, 4'hF, 4'hF, '{4'h3, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL up_wrap[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  task automatic test_down_wrap();
    row_t rows[$];
    exp_t got;
    rows.push_back('{1'b1, MODE_JK,   4'h1, 4'hE, '{4'h1, 1'b0}});
    rows.push_back('{1'b1, MODE_DOWN, 4'h0, 4'h0, '{4'h0, 1'b1}});
    rows.push_back('{1'b1, MODE_DOWN, 4'h0, 4'h0, '{4'hF, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL down_wrap[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
    // Mode switch at all ones: tc follows mode without a clock edge.
    mode = MODE_UP;
    sb.push_back('{4'hF, 1'b1});
    #1;
    got = sb.pop_front();
    n_cmp++;
    if (q !== got.q || tc !== got.tc) begin
      n_bad++;
      $display("FAIL down_to_up_tc: q=%h tc=%b, want q=%h tc=%b", q, tc, got.q, got.tc);
    end
    en = 1'b0;
    sb.push_back('{4'hF, 1'b0});
    #1;
    got = sb.pop_front();
    n_cmp++;
    if (q !== got.q || tc !== got.tc) begin
      n_bad++;
      $display("FAIL tc_en_gate: q=%h tc=%b, want q=%h tc=%b", q, tc, got.q, got.tc);
    end
    rows.delete();
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h0, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL up_after_down[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  task automatic test_shift();
    row_t rows[$];
    exp_t got;
    logic [W-1:0] rj;
    rows.push_back('{1'b1, MODE_JK, 4'h0, 4'hF, '{4'h0, 1'b0}});
    rows.push_back('{1'b1, MODE_SHIFT, 4'h1, 4'h0, '{4'h1, 1'b0}});
    rows.push_back('{1'b1, MODE_SHIFT, 4'h0, 4'h0, '{4'h2, 1'b0}});
    rows.push_back('{1'b1, MODE_SHIFT, 4'h1, 4'h0, '{4'h5, 1'b0}});
    rows.push_back('{1'b1, MODE_SHIFT, 4'h1, 4'h0, '{4'hB, 1'b0}});
    rows.push_back('{1'b1, MODE_SHIFT, 4'h0, 4'h0, '{4'h6, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      // Upper j bits and all of k are don't-care while shifting.
      if (rows[i].mode == MODE_SHIFT) begin
        rj = W'($urandom_range(0, 15));
        j  = {rj[W-1:1], rows[i].j[0]};
        k  = W'($urandom_range(0, 15));
      end
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL shift[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  task automatic test_async_mid_count();
    row_t rows[$];
    exp_t got;
    rows.push_back('{1'b1, MODE_JK, 4'h7, 4'h8, '{4'h7, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL async_load[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
    en   = 1'b1;
    mode = MODE_UP;
    #3;
    reset = 1'b0;
    sb.push_back('{4'h0, 1'b0});
    #1;
    got = sb.pop_front();
    n_cmp++;
    if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
      n_bad++;
      $display("FAIL async_drop: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
               q, qnot, tc, got.q, ~got.q, got.tc);
    end
    rows.delete();
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h0, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h0, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h0, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL async_hold[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
    #3;
    reset = 1'b1;
    rows.delete();
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h1, 1'b0}});
    rows.push_back('{1'b1, MODE_UP, 4'h0, 4'h0, '{4'h2, 1'b0}});
    foreach (rows[i]) begin
      en = rows[i].en; mode = rows[i].mode; j = rows[i].j; k = rows[i].k;
      sb.push_back(rows[i].e);
      @(posedge clk); #1;
      got = sb.pop_front();
      n_cmp++;
      if (q !== got.q || qnot !== ~got.q || tc !== got.tc) begin
        n_bad++;
        $display("FAIL async_resume[%0d]: q=%h qnot=%h tc=%b, want q=%h qnot=%h tc=%b",
                 i, q, qnot, tc, got.q, ~got.q, got.tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_up_wrap();
    test_down_wrap();
    test_shift();
    test_async_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_jkff_bank
